// File: rtl/conv2d_tile_sched.sv
// conv2d_tile_sched: loads a WIN_SIZE x WIN_SIZE coefficient kernel, then walks
// the output image in PIX_PER_CLK-wide beats, issuing window fetches to the line
// buffer under an output-buffer credit scheme, and drains in-flight MAC results.
// Optional feature macro: CONV2D_SCHED_KEEP_COEF_EN (adds cfg_keep_coef so a
// job can reuse the kernel loaded by a previous job and skip LOAD).
module conv2d_tile_sched #(
  parameter int unsigned WIN_SIZE    = 3,
  parameter int unsigned COEF_W      = 8,
  parameter int unsigned PIX_PER_CLK = 8,
  parameter int unsigned DIM_W       = 12,
  parameter int unsigned OUT_CREDITS = 4
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                cfg_start,
  input  logic [DIM_W-1:0]                    cfg_width,
  input  logic [DIM_W-1:0]                    cfg_height,
`ifdef CONV2D_SCHED_KEEP_COEF_EN
  input  logic                                cfg_keep_coef,
`endif
  input  logic                                coef_valid,
  output logic                                coef_ready,
  input  logic [COEF_W-1:0]                   coef_data,
  output logic [WIN_SIZE*WIN_SIZE*COEF_W-1:0] kernel_flat,
  output logic                                fetch_valid,
  input  logic                                fetch_ready,
  output logic [DIM_W-1:0]                    fetch_row,
  output logic [DIM_W-1:0]                    fetch_col,
  output logic                                mac_in_valid,
  input  logic                                mac_out_valid,
  input  logic                                res_pop,
  output logic                                busy,
  output logic                                done,
  output logic                                err
);

  localparam int unsigned N     = WIN_SIZE * WIN_SIZE;
  localparam int unsigned IDX_W = (N > 1) ? $clog2(N) : 1;
  localparam int unsigned CRD_W = $clog2(OUT_CREDITS + 1);
  localparam int unsigned OUT_W = CRD_W + 1;
  localparam int unsigned EXT_W = DIM_W + 1;

  typedef enum logic [2:0] {IDLE, LOAD, RUN, DRAIN, DONE} state_t;

  state_t                  state_q, state_d;
  logic [DIM_W-1:0]        width_q, height_q;
  logic [DIM_W-1:0]        row_q, col_q;
  logic [IDX_W-1:0]        coef_idx_q;
  logic [N*COEF_W-1:0]     kernel_q;
  logic [CRD_W-1:0]        credits_q, credits_d;
  logic [OUT_W-1:0]        outstanding_q, outstanding_d;
  logic                    err_q, err_set_c;
`ifdef CONV2D_SCHED_KEEP_COEF_EN
  logic                    kernel_loaded_q;
`endif

  logic                    coef_acc_c, last_coef_c, job_empty_c;
  logic                    wrap_c, last_row_c, last_beat_c, out_dec_c;
  logic [EXT_W-1:0]        col_ext_c;

  // Decode of handshakes and scan position
  assign coef_ready   = (state_q == LOAD);
  assign coef_acc_c   = coef_valid && coef_ready;
  assign last_coef_c  = (coef_idx_q == IDX_W'(N - 1));
  assign job_empty_c  = (width_q == '0) || (height_q == '0);
  assign fetch_valid  = (state_q == RUN) && (credits_q != '0);
  assign mac_in_valid = fetch_valid && fetch_ready;
  assign col_ext_c    = {1'b0, col_q} + EXT_W'(PIX_PER_CLK);
  assign wrap_c       = (col_ext_c >= {1'b0, width_q});
  assign last_row_c   = (row_q == (height_q - DIM_W'(1)));
  assign last_beat_c  = wrap_c && last_row_c;
  assign fetch_row    = row_q;
  assign fetch_col    = col_q;
  assign kernel_flat  = kernel_q;
  assign busy         = (state_q == LOAD) || (state_q == RUN) || (state_q == DRAIN);
  assign done         = (state_q == DONE);
  assign err          = err_q;

  // Credit / outstanding next values and protocol-error detection
  always_comb begin
    credits_d     = credits_q;
    outstanding_d = outstanding_q;
    out_dec_c     = mac_out_valid && (outstanding_q != '0);
    err_set_c     = (res_pop && (credits_q == CRD_W'(OUT_CREDITS))) ||
                    (mac_out_valid && (outstanding_q == '0));
    if (mac_in_valid && !res_pop)
      credits_d = credits_q - CRD_W'(1);
    else if (res_pop && !mac_in_valid && (credits_q != CRD_W'(OUT_CREDITS)))
      credits_d = credits_q + CRD_W'(1);
    if (mac_in_valid && !out_dec_c)
      outstanding_d = outstanding_q + OUT_W'(1);
    else if (!mac_in_valid && out_dec_c)
      outstanding_d = outstanding_q - OUT_W'(1);
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (cfg_start) begin
          state_d = LOAD;
`ifdef CONV2D_SCHED_KEEP_COEF_EN
          if (cfg_keep_coef && kernel_loaded_q)
            state_d = ((cfg_width == '0) || (cfg_height == '0)) ? DONE : RUN;
`endif
        end
      end
      LOAD:    if (coef_acc_c && last_coef_c) state_d = job_empty_c ? DONE : RUN;
      RUN:     if (mac_in_valid && last_beat_c) state_d = DRAIN;
      DRAIN:   if (outstanding_d == '0) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State, job registers, kernel storage and counters
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= IDLE;
      width_q         <= '0;
      height_q        <= '0;
      row_q           <= '0;
      col_q           <= '0;
      coef_idx_q      <= '0;
      kernel_q        <= '0;
      credits_q       <= CRD_W'(OUT_CREDITS);
      outstanding_q   <= '0;
      err_q           <= 1'b0;
`ifdef CONV2D_SCHED_KEEP_COEF_EN
      kernel_loaded_q <= 1'b0;
`endif
    end else begin
      state_q       <= state_d;
      credits_q     <= credits_d;
      outstanding_q <= outstanding_d;
      if (err_set_c) err_q <= 1'b1;
      if ((state_q == IDLE) && cfg_start) begin
        width_q    <= cfg_width;
        height_q   <= cfg_height;
        row_q      <= '0;
        col_q      <= '0;
        coef_idx_q <= '0;
      end
      if (coef_acc_c) begin
        kernel_q[coef_idx_q*COEF_W +: COEF_W] <= coef_data;
        coef_idx_q <= coef_idx_q + IDX_W'(1);
`ifdef CONV2D_SCHED_KEEP_COEF_EN
        if (last_coef_c) kernel_loaded_q <= 1'b1;
`endif
      end
      if (mac_in_valid) begin
        if (wrap_c) begin
          col_q <= '0;
          row_q <= row_q + DIM_W'(1);
        end else begin
          col_q <= col_ext_c[DIM_W-1:0];
        end
      end
    end
  end

endmodule

// File: tb/tb_conv2d_tile_sched.sv
// Directed bench for conv2d_tile_sched: a two-cycle MAC latency model, a beat
// monitor, and hand-computed expected beats, kernels and handshake timing.
module tb_conv2d_tile_sched;

  localparam int unsigned WIN_SIZE    = 3;
  localparam int unsigned COEF_W      = 8;
  localparam int unsigned PIX_PER_CLK = 8;
  localparam int unsigned DIM_W       = 12;
  localparam int unsigned OUT_CREDITS = 4;
  localparam int unsigned N           = WIN_SIZE * WIN_SIZE;
  localparam int unsigned KW          = N * COEF_W;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              cfg_start = 1'b0;
  logic [DIM_W-1:0]  cfg_width = '0;
  logic [DIM_W-1:0]  cfg_height = '0;
`ifdef CONV2D_SCHED_KEEP_COEF_EN
  logic              cfg_keep_coef = 1'b0;
`endif
  logic              coef_valid = 1'b0;
  logic              coef_ready;
  logic [COEF_W-1:0] coef_data = '0;
  logic [KW-1:0]     kernel_flat;
  logic              fetch_valid;
  logic              fetch_ready = 1'b0;
  logic [DIM_W-1:0]  fetch_row, fetch_col;
  logic              mac_in_valid;
  logic              mac_out_valid;
  logic              res_pop;
  logic              busy, done, err;

  logic              pop_mode = 1'b0;
  logic              pop_pulse = 1'b0;
  logic              force_out = 1'b0;
  logic [1:0]        hist = 2'b00;
  logic              mi_s = 1'b0;
  logic              rst_s = 1'b1;
  int                cyc = 0;
  int                last_out_cyc = 0;
  int                done_cyc = 0;
  int                n_vec = 0;
  int                n_bad = 0;
  logic [DIM_W-1:0]  beat_row[$];
  logic [DIM_W-1:0]  beat_col[$];
  logic [KW-1:0]     exp_k;

  conv2d_tile_sched #(
    .WIN_SIZE(WIN_SIZE), .COEF_W(COEF_W), .PIX_PER_CLK(PIX_PER_CLK),
    .DIM_W(DIM_W), .OUT_CREDITS(OUT_CREDITS)
  ) dut (
    .clk(clk), .rst(rst), .cfg_start(cfg_start),
    .cfg_width(cfg_width), .cfg_height(cfg_height),
`ifdef CONV2D_SCHED_KEEP_COEF_EN
    .cfg_keep_coef(cfg_keep_coef),
`endif
    .coef_valid(coef_valid), .coef_ready(coef_ready), .coef_data(coef_data),
    .kernel_flat(kernel_flat), .fetch_valid(fetch_valid), .fetch_ready(fetch_ready),
    .fetch_row(fetch_row), .fetch_col(fetch_col), .mac_in_valid(mac_in_valid),
    .mac_out_valid(mac_out_valid), .res_pop(res_pop),
    .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // MAC array model: a result beat two cycles after each accepted fetch
  always @(negedge clk) begin
    mi_s  = mac_in_valid;
    rst_s = rst;
  end
  always @(posedge clk) begin
    #1;
    hist = rst_s ? 2'b00 : {hist[0], mi_s};
  end
  assign mac_out_valid = hist[1] | force_out;
  assign res_pop       = pop_mode | pop_pulse;

  // Beat and event monitor, sampled mid-cycle
  always @(negedge clk) begin
    if (mac_in_valid) begin
      beat_row.push_back(fetch_row);
      beat_col.push_back(fetch_col);
    end
    if (mac_out_valid) last_out_cyc = cyc;
    if (done) done_cyc = cyc;
  end

  task automatic check(input string tag, input logic [KW-1:0] got, input logic [KW-1:0] expv);
    n_vec++;
    if (got !== expv) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, expv);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
    #1;
  endtask

  task automatic start_job(input int w, input int h);
    beat_row.delete();
    beat_col.delete();
    cfg_width  = DIM_W'(w);
    cfg_height = DIM_W'(h);
    cfg_start  = 1'b1;
    step();
    cfg_start  = 1'b0;
  endtask

  task automatic load_coefs(input logic [COEF_W-1:0] first, input logic [COEF_W-1:0] stride,
                            output logic [KW-1:0] expv);
    expv = '0;
    for (int i = 0; i < int'(N); i++) begin
      coef_valid = 1'b1;
      coef_data  = first + COEF_W'(i) * stride;
      expv[i*COEF_W +: COEF_W] = coef_data;
      step();
    end
    coef_valid = 1'b0;
  endtask

  task automatic check_beat(input string tag, input int i, input int r, input int c);
    if (i < beat_row.size()) begin
      check({tag, "_row"}, KW'(beat_row[i]), KW'(r));
      check({tag, "_col"}, KW'(beat_col[i]), KW'(c));
    end else begin
      check({tag, "_missing"}, KW'(0), KW'(1));
    end
  endtask

  task automatic wait_done(input string tag, input int budget);
    bit seen = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      mid();
      if (done) seen = 1'b1;
    end
    check({tag, "_done_seen"}, KW'(seen), KW'(1));
    mid();
    check({tag, "_done_one_cycle"}, KW'(done), KW'(0));
    check({tag, "_idle_busy"}, KW'(busy), KW'(0));
    step();
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_coef_ready"}, KW'(coef_ready), KW'(0));
    check({tag, "_fetch_valid"}, KW'(fetch_valid), KW'(0));
    check({tag, "_fetch_row"}, KW'(fetch_row), KW'(0));
    check({tag, "_fetch_col"}, KW'(fetch_col), KW'(0));
    check({tag, "_mac_in_valid"}, KW'(mac_in_valid), KW'(0));
    check({tag, "_busy"}, KW'(busy), KW'(0));
    check({tag, "_done"}, KW'(done), KW'(0));
    check({tag, "_err"}, KW'(err), KW'(0));
    check({tag, "_kernel"}, kernel_flat, KW'(0));
  endtask

  // 16x2 job, coefficients 1..9, every beat accepted and popped
  task automatic std_job(input string tag);
    start_job(16, 2);
    load_coefs(8'd1, 8'd1, exp_k);
    check({tag, "_kernel"}, kernel_flat, 72'h09_08_07_06_05_04_03_02_01);
    check({tag, "_busy_run"}, KW'(busy), KW'(1));
    wait_done(tag, 100);
    check({tag, "_n_beats"}, KW'(beat_row.size()), KW'(4));
    check_beat({tag, "_b0"}, 0, 0, 0);
    check_beat({tag, "_b1"}, 1, 0, 8);
    check_beat({tag, "_b2"}, 2, 1, 0);
    check_beat({tag, "_b3"}, 3, 1, 8);
    check({tag, "_done_after_result"}, KW'(done_cyc - last_out_cyc), KW'(1));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    step();
    step();
    check_reset_outputs("reset");
    rst = 1'b0;
    step();

    // Basic 16x2 job
    fetch_ready = 1'b1;
    pop_mode    = 1'b1;
    std_job("basic");

    // 20x1: partial last beat at col 16, then DRAIN
    start_job(20, 1);
    load_coefs(8'hFF, 8'hFF, exp_k);
    check("w20_kernel", kernel_flat, 72'hF7_F8_F9_FA_FB_FC_FD_FE_FF);
    mid(); mid(); mid(); mid();
    check("w20_drain_busy", KW'(busy), KW'(1));
    check("w20_drain_fetch_valid", KW'(fetch_valid), KW'(0));
    check("w20_wrap_row", KW'(fetch_row), KW'(1));
    check("w20_wrap_col", KW'(fetch_col), KW'(0));
    wait_done("w20", 50);
    check("w20_n_beats", KW'(beat_row.size()), KW'(3));
    check_beat("w20_b0", 0, 0, 0);
    check_beat("w20_b1", 1, 0, 8);
    check_beat("w20_b2", 2, 0, 16);

    // Credit limit: no pops -> 4 beats, one pop -> one more beat
    step();
    pop_mode = 1'b0;
    start_job(64, 1);
    load_coefs(8'd3, 8'd2, exp_k);
    check("cred_kernel", kernel_flat, exp_k);
    for (int i = 0; i < 8; i++) mid();
    check("cred_n_beats_4", KW'(beat_row.size()), KW'(4));
    check("cred_stall_fetch_valid", KW'(fetch_valid), KW'(0));
    step();
    pop_pulse = 1'b1;
    step();
    pop_pulse = 1'b0;
    for (int i = 0; i < 4; i++) mid();
    check("cred_n_beats_5", KW'(beat_row.size()), KW'(5));
    check("cred_stall2_fetch_valid", KW'(fetch_valid), KW'(0));
    step();
    pop_mode = 1'b1;
    wait_done("cred", 100);
    check("cred_n_beats_8", KW'(beat_row.size()), KW'(8));
    check_beat("cred_b7", 7, 0, 56);

    // Backpressure: fetch_ready low for 5 cycles after one beat
    fetch_ready = 1'b0;
    start_job(32, 1);
    load_coefs(8'h10, 8'h01, exp_k);
    fetch_ready = 1'b1;
    step();
    fetch_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      mid();
      check("bp_fetch_valid", KW'(fetch_valid), KW'(1));
      check("bp_fetch_row", KW'(fetch_row), KW'(0));
      check("bp_fetch_col", KW'(fetch_col), KW'(8));
      check("bp_n_beats", KW'(beat_row.size()), KW'(1));
    end
    step();
    fetch_ready = 1'b1;
    wait_done("bp", 100);
    check("bp_n_beats_total", KW'(beat_row.size()), KW'(4));
    check_beat("bp_b3", 3, 0, 24);

    // Reset mid-RUN after two beats, then a fresh basic job
    start_job(64, 2);
    load_coefs(8'h20, 8'h03, exp_k);
    step();
    step();
    rst         = 1'b1;
    fetch_ready = 1'b0;
    step();
    check("rr_n_beats", KW'(beat_row.size()), KW'(2));
    check_reset_outputs("rr");
    rst         = 1'b0;
    fetch_ready = 1'b1;
    step();
    std_job("rr_job");

    // Spurious MAC result in IDLE, then an empty job
    rst      = 1'b1;
    pop_mode = 1'b0;
    step();
    rst = 1'b0;
    step();
    check("spur_err_before", KW'(err), KW'(0));
    force_out = 1'b1;
    step();
    force_out = 1'b0;
    check("spur_err_set", KW'(err), KW'(1));
    step();
    step();
    check("spur_err_sticky", KW'(err), KW'(1));
    start_job(0, 5);
    load_coefs(8'd7, 8'd1, exp_k);
    check("empty_done", KW'(done), KW'(1));
    check("empty_busy", KW'(busy), KW'(0));
    step();
    check("empty_done_cleared", KW'(done), KW'(0));
    check("empty_n_beats", KW'(beat_row.size()), KW'(0));
    check("empty_err_sticky", KW'(err), KW'(1));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/conv2d_tile_sched.md
CONV2D_TILE_SCHED -- requirements
Module: conv2d_tile_sched

Interface
REQ-001 Parameter WIN_SIZE, default 3, kernel edge length; the block loads WIN_SIZE*WIN_SIZE coefficients.
REQ-002 Parameter COEF_W, default 8, coefficient width.
REQ-003 Parameter PIX_PER_CLK, default 8, output pixels per MAC beat.
REQ-004 Parameter DIM_W, default 12, width of image dimension and position fields.
REQ-005 Parameter OUT_CREDITS, default 4, output-buffer beat credits.
REQ-006 Port clk, input, 1, clock.
REQ-007 Port rst, input, 1, reset; synchronous, active-high.
REQ-008 Port cfg_start, input, 1, start pulse.
REQ-009 Port cfg_width, input, DIM_W, output columns.
REQ-010 Port cfg_height, input, DIM_W, output rows.
REQ-011 Port coef_valid / coef_ready, input / output, 1 each, coefficient handshake.
REQ-012 Port coef_data, input, COEF_W, signed coefficient, row-major order.
REQ-013 Port kernel_flat, output, WIN_SIZE*WIN_SIZE*COEF_W, held coefficients to the MAC array; index k sits at bits [k*COEF_W +: COEF_W].
REQ-014 Port fetch_valid / fetch_ready, output / input, 1 each, window-fetch handshake to the line buffer.
REQ-015 Port fetch_row and fetch_col, output, DIM_W each, top-left output position of the beat.
REQ-016 Port mac_in_valid, output, 1, equals fetch_valid AND fetch_ready.
REQ-017 Port mac_out_valid, input, 1, result beat produced by the MAC array.
REQ-018 Port res_pop, input, 1, downstream consumed one buffered result beat.
REQ-019 Ports busy, done, and err, output, 1 each.

Function
REQ-020 FSM states SHALL be IDLE, LOAD, RUN, DRAIN, and DONE.
REQ-021 IDLE SHALL act on cfg_start=1 as follows: latch cfg_width and cfg_height, clear the counters, and go to LOAD; cfg_start SHALL be ignored in every other state.
REQ-022 LOAD SHALL hold coef_ready=1; each coef_valid&&coef_ready writes coefficient index 0..N-1; on the Nth accept the FSM SHALL go to RUN.
REQ-023 kernel_flat SHALL change only during LOAD.
REQ-024 RUN SHALL assert fetch_valid only while credits > 0; fetch_row, fetch_col, and fetch_valid SHALL remain stable until accepted.
REQ-025 On each accepted beat, fetch_col SHALL advance by PIX_PER_CLK.
REQ-026 When fetch_col+PIX_PER_CLK >= width, fetch_col SHALL wrap to 0 and fetch_row SHALL increment.
REQ-027 A partial last beat SHALL still be issued as a full beat.
REQ-028 After the beat at the last row and last column is accepted, the FSM SHALL go to DRAIN.
REQ-029 Credits SHALL reset to OUT_CREDITS, decrement on mac_in_valid, and increment on res_pop.
REQ-030 A simultaneous mac_in_valid and res_pop SHALL leave credits unchanged.
REQ-031 res_pop with credits == OUT_CREDITS SHALL set err and leave credits unchanged.
REQ-032 The outstanding counter SHALL increment on mac_in_valid and decrement on mac_out_valid.
REQ-033 mac_out_valid with outstanding == 0 SHALL set err.
REQ-034 DRAIN SHALL go to DONE when outstanding == 0.
REQ-035 DONE SHALL assert done for exactly one cycle, then return to IDLE.
REQ-036 width==0 or height==0 at start SHALL still run LOAD, then go directly to DONE with no fetch.
REQ-037 busy SHALL be 1 in LOAD, RUN, and DRAIN, and 0 otherwise.
REQ-038 err SHALL be sticky until rst.

Reset
REQ-039 On rst: state IDLE, coef_ready=0, fetch_valid=0, fetch_row=0, fetch_col=0, mac_in_valid=0, busy=0, done=0, err=0, kernel_flat all zero, credits=OUT_CREDITS, outstanding=0.
REQ-040 rst SHALL take effect from any state, including mid-RUN or mid-LOAD, on the next clk edge, abandoning the job.

Configuration
REQ-041 With CONV2D_SCHED_KEEP_COEF_EN defined, input cfg_keep_coef (1 bit) SHALL exist; cfg_start with cfg_keep_coef=1 and a kernel completed since rst SHALL go IDLE->RUN and skip LOAD; otherwise the FSM SHALL go to LOAD.
REQ-042 With CONV2D_SCHED_KEEP_COEF_EN undefined, the port SHALL be absent and LOAD SHALL always occur.

Verification
REQ-043 rst, start width=16 height=2, coefficients 1..9, fetch_ready=1, res_pop every cycle, mac_out_valid 2 cycles after mac_in_valid -> kernel_flat holds 1..9, beats (0,0),(0,8),(1,0),(1,8), done one cycle after last result.
REQ-044 width=20 height=1 -> beats at col 0, 8, 16 (wrap after 16), then DRAIN.
REQ-045 OUT_CREDITS=4, res_pop=0 -> exactly 4 beats issued, fetch_valid low; one res_pop -> exactly one more beat.
REQ-046 fetch_ready=0 for 5 cycles mid-RUN -> fetch_row, fetch_col, and fetch_valid stable; no extra beats issued.
REQ-047 rst asserted in RUN after 2 beats -> next cycle all outputs at reset values; new start behaves as in REQ-043.
REQ-048 Spurious mac_out_valid in IDLE -> err=1 and held; width=0 -> done pulse with zero fetches.
